// File: rtl/step_if.sv
// step_if: signal bundle between the step controller and its surroundings.
//   master: the board side (debouncer, switches, ARM core) that drives the
//           requests, breakpoint settings and PC, and observes the enable.
//   slave:  the step controller itself.
// Signals:
//   step_pulse  one-clk request for a single step
//   mode_pulse  one-clk request to toggle STEP<->RUN or resume from BREAK
//   bp_en       breakpoint enable (level)
//   bp_addr     breakpoint address
//   pc          current core PC, advances on the edge ending a cpu_en cycle
//   cpu_en      one-clk enable to the core
//   halted      1 in IDLE and BREAK
//   state       controller state (00 IDLE, 01 RUN, 10 BREAK)
//   step_count  number of cpu_en pulses issued, wraps
// Protocol: there is no valid/ready pairing here. step_pulse and mode_pulse
// are single-cycle strobes sampled on every rising clk edge; a strobe that
// arrives when it has no meaning in the current state is dropped, never
// queued. cpu_en is a single-cycle strobe that the core must accept.
interface step_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             step_pulse;
    logic             mode_pulse;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             cpu_en;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] step_count;

    modport master (
        output step_pulse, mode_pulse, bp_en, bp_addr, pc,
        input  cpu_en, halted, state, step_count
    );

    modport slave (
        input  step_pulse, mode_pulse, bp_en, bp_addr, pc,
        output cpu_en, halted, state, step_count
    );
endinterface

// File: rtl/step_controller.sv
// step_controller: generates the single-cycle CPU clock-enable.
//   Modes: manual single-step (IDLE), free-run at one pulse per RUN_DIV clk
//   cycles (RUN), and stop on a PC breakpoint (BREAK). The core clock is
//   never gated; cpu_en is a synchronous enable.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    step_if slave: pulses/breakpoint/pc in, cpu_en/halted/state/
//          step_count out (all outputs registered)
module step_controller #(
    parameter int RUN_DIV = 25_000_000,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic   clk,
    input  logic   reset,
    step_if.slave  bus
);
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_BREAK = 2'b10,
        S_ILL   = 2'b11
    } state_t;

    state_t           state_q, state_n;
    logic             cpu_en_q, cpu_en_n;
    logic             halted_q, halted_n;
    logic             moved_q, moved_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [PC_W-1:0]  pc_v, bp_v;
    logic             tick, bp_hit, issue;

    assign pc_v = bus.pc;
    assign bp_v = bus.bp_addr;
    assign tick = (div_q == DIV_LAST);
    // cpu_en_q blocks the hit while the core is still finishing a step, so
    // the compare only ever sees a settled PC. moved_q keeps a resume that
    // starts on the breakpoint address from re-trapping immediately.
    assign bp_hit = bus.bp_en && moved_q && (pc_v == bp_v) && !cpu_en_q;

    // State register (all registered outputs live here too)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b1;
            moved_q  <= 1'b0;
            div_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_n;
            cpu_en_q <= cpu_en_n;
            halted_q <= halted_n;
            moved_q  <= moved_n;
            div_q    <= div_n;
            count_q  <= count_n;
        end
    end

    // Next-state logic; mode_pulse always has priority over step_pulse
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (bus.mode_pulse) state_n = S_RUN;
            S_RUN: begin
                if (bus.mode_pulse)  state_n = S_IDLE;
                else if (bp_hit)     state_n = S_BREAK;
            end
            S_BREAK: begin
                if (bus.mode_pulse)      state_n = S_RUN;
                else if (bus.step_pulse) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output / datapath logic, computing next values of the registered outputs
    always_comb begin
        issue   = 1'b0;
        div_n   = div_q;
        moved_n = moved_q;
        case (state_q)
            S_IDLE, S_BREAK: begin
                if (bus.mode_pulse) begin
                    div_n   = '0;
                    moved_n = 1'b0;
                end else if (bus.step_pulse) begin
                    issue = 1'b1;
                end
            end
            S_RUN: begin
                // Leaving RUN (mode or breakpoint) suppresses a coincident tick
                if (!bus.mode_pulse && !bp_hit) begin
                    if (tick) begin
                        issue   = 1'b1;
                        div_n   = '0;
                        moved_n = 1'b1;
                    end else begin
                        div_n = div_q + DIV_W'(1);
                    end
                end
            end
            default: ;
        endcase
        cpu_en_n = issue;
        count_n  = count_q + CNT_W'(issue);
        halted_n = (state_n != S_RUN);
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.halted     = halted_q;
    assign bus.state      = state_q;
    assign bus.step_count = count_q;
endmodule

// File: tb/tb_step_controller.sv
module tb_step_controller;
    localparam int RUN_DIV = 4;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 16;
    localparam int CNT_WS  = 4;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_BREAK = 2'b10;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic            step_pulse = 1'b0;
    logic            mode_pulse = 1'b0;
    logic            bp_en      = 1'b0;
    logic [PC_W-1:0] bp_addr    = '0;
    logic [PC_W-1:0] pc   = '0;
    logic [PC_W-1:0] pc_s = '0;

    int checks = 0;
    int errors = 0;

    step_if #(.PC_W(PC_W), .CNT_W(CNT_W))  bus   ();
    step_if #(.PC_W(PC_W), .CNT_W(CNT_WS)) bus_s ();

    assign bus.step_pulse   = step_pulse;
    assign bus.mode_pulse   = mode_pulse;
    assign bus.bp_en        = bp_en;
    assign bus.bp_addr      = bp_addr;
    assign bus.pc           = pc;
    assign bus_s.step_pulse = step_pulse;
    assign bus_s.mode_pulse = mode_pulse;
    assign bus_s.bp_en      = bp_en;
    assign bus_s.bp_addr    = bp_addr;
    assign bus_s.pc         = pc_s;

    step_controller #(.RUN_DIV(RUN_DIV), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Narrow-counter instance used to reach the step_count wrap quickly
    step_controller #(.RUN_DIV(RUN_DIV), .PC_W(PC_W), .CNT_W(CNT_WS)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    // Model core: pc advances by 4 on each cpu_en
    always @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else if (bus.cpu_en) pc <= pc + 32'd4;
    end
    always @(posedge clk or negedge reset) begin
        if (!reset) pc_s <= '0;
        else if (bus_s.cpu_en) pc_s <= pc_s + 32'd4;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic en);
        check({tag, " state"},  32'(bus.state),  32'(st));
        check({tag, " cpu_en"}, 32'(bus.cpu_en), 32'(en));
        check({tag, " halted"}, 32'(bus.halted), 32'(st != ST_RUN));
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        step;
        logic        mode;
        logic [1:0]  st;
        logic        en;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[24];

    initial begin
        // step/mode applied for one cycle; outputs expected after that edge
        vecs[0]  = '{1'b0, 1'b0, ST_IDLE, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, ST_IDLE, 1'b1, 16'd1};  // single step
        vecs[2]  = '{1'b0, 1'b0, ST_IDLE, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 1'b1, ST_RUN,  1'b0, 16'd1};  // enter RUN, div=0
        vecs[4]  = '{1'b1, 1'b0, ST_RUN,  1'b0, 16'd1};  // step ignored in RUN
        vecs[5]  = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, ST_RUN,  1'b1, 16'd2};  // RUN_DIV cycles after entry
        vecs[8]  = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd2};
        vecs[9]  = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd2};
        vecs[10] = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd2};
        vecs[11] = '{1'b0, 1'b0, ST_RUN,  1'b1, 16'd3};
        vecs[12] = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd3};
        vecs[13] = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd3};
        vecs[14] = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd3};
        vecs[15] = '{1'b0, 1'b1, ST_IDLE, 1'b0, 16'd3};  // mode cancels coincident tick
        vecs[16] = '{1'b0, 1'b0, ST_IDLE, 1'b0, 16'd3};
        vecs[17] = '{1'b1, 1'b1, ST_RUN,  1'b0, 16'd3};  // mode beats step
        vecs[18] = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd3};
        vecs[19] = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd3};
        vecs[20] = '{1'b0, 1'b0, ST_RUN,  1'b0, 16'd3};
        vecs[21] = '{1'b0, 1'b0, ST_RUN,  1'b1, 16'd4};
        vecs[22] = '{1'b0, 1'b1, ST_IDLE, 1'b0, 16'd4};
        vecs[23] = '{1'b0, 1'b0, ST_IDLE, 1'b0, 16'd4};
    end

    // ---------------- test sequence ----------------
    initial begin
        logic exp_en;
        logic [1:0] exp_st;

        // Reset held low for 3 cycles, with a step request that must be dropped
        #2 reset = 1'b0;
        step_pulse = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_out($sformatf("reset[%0d]", i), ST_IDLE, 1'b0);
            check($sformatf("reset[%0d] count", i), 32'(bus.step_count), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        step_pulse = 1'b0;
        @(posedge clk); #1;
        check_out("post_reset", ST_IDLE, 1'b0);
        check("post_reset count", 32'(bus.step_count), 32'd0);

        // Table-driven IDLE/RUN vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            step_pulse = vecs[i].step;
            mode_pulse = vecs[i].mode;
            @(posedge clk); #1;
            check_out($sformatf("vec[%0d]", i), vecs[i].st, vecs[i].en);
            check($sformatf("vec[%0d] count", i), 32'(bus.step_count), 32'(vecs[i].cnt));
        end
        @(negedge clk);
        step_pulse = 1'b0;
        mode_pulse = 1'b0;
        check("table pc", pc, 32'h10);

        // Breakpoint at 0x8 running from pc=0
        pulse_reset();
        bp_en   = 1'b1;
        bp_addr = 32'h8;
        mode_pulse = 1'b1;
        @(posedge clk); #1;
        check_out("bp enter", ST_RUN, 1'b0);
        @(negedge clk) mode_pulse = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            exp_en = (k == 4 || k == 8);
            exp_st = (k >= 10) ? ST_BREAK : ST_RUN;
            check_out($sformatf("bp k%0d", k), exp_st, exp_en);
            // Breakpoint settings changed inside BREAK must not matter
            if (k == 12) bp_addr = 32'h40;
            if (k == 14) bp_en = 1'b0;
        end
        check("bp count", 32'(bus.step_count), 32'd2);
        check("bp pc", pc, 32'h8);

        // Resume from BREAK; leaves 0x8, then traps again at 0x10
        @(negedge clk) mode_pulse = 1'b1;
        @(posedge clk); #1;
        check_out("resume", ST_RUN, 1'b0);
        @(negedge clk) mode_pulse = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            exp_en = (k == 4 || k == 8);
            exp_st = (k >= 10) ? ST_BREAK : ST_RUN;
            check_out($sformatf("resume k%0d", k), exp_st, exp_en);
            if (k == 5) check("resume pc", pc, 32'hC);
            if (k == 1) begin
                bp_en   = 1'b1;
                bp_addr = 32'h10;
            end
        end
        check("resume count", 32'(bus.step_count), 32'd4);

        // In BREAK, step and mode together: mode wins
        @(negedge clk);
        step_pulse = 1'b1;
        mode_pulse = 1'b1;
        bp_addr    = 32'h14;
        @(posedge clk); #1;
        check_out("break both", ST_RUN, 1'b0);
        @(negedge clk);
        step_pulse = 1'b0;
        mode_pulse = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check_out($sformatf("rebreak k%0d", k), (k >= 6) ? ST_BREAK : ST_RUN, k == 4);
        end

        // Step out of BREAK: one pulse, back to IDLE
        @(negedge clk) step_pulse = 1'b1;
        @(posedge clk); #1;
        check_out("break step", ST_IDLE, 1'b1);
        check("break step count", 32'(bus.step_count), 32'd6);
        @(negedge clk) step_pulse = 1'b0;
        @(posedge clk); #1;
        check_out("break step after", ST_IDLE, 1'b0);
        check("break step pc", pc, 32'h18);
        bp_en = 1'b0;

        // Asynchronous reset in RUN with div=2
        @(negedge clk) mode_pulse = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) mode_pulse = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check_out("async reset", ST_IDLE, 1'b0);
        check("async reset count", 32'(bus.step_count), 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check_out($sformatf("after reset k%0d", k), ST_IDLE, 1'b0);
        end

        // step_count wrap on the narrow instance: 16 steps -> 0, 17 -> 1
        @(negedge clk) step_pulse = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("wrap small count", 32'(bus_s.step_count), 32'd0);
        check("wrap main count", 32'(bus.step_count), 32'd16);
        check("wrap cpu_en", 32'(bus_s.cpu_en), 32'd1);
        @(posedge clk); #1;
        check("wrap small +1", 32'(bus_s.step_count), 32'd1);
        @(negedge clk) step_pulse = 1'b0;
        @(posedge clk); #1;
        check("wrap idle cpu_en", 32'(bus_s.cpu_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
